// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT block-floating-point (CBFP) stages.
package fft_pkg;
    localparam int LANES          = 16;
    localparam int BEATS          = 32;
    localparam int CBFP_WIDTH_IN  = 13;
    localparam int CBFP_WIDTH_OUT = 16;
    localparam int CBFP_OFFSET    = 12;

    typedef logic [5:0] exp_t;
    typedef logic [4:0] idx_t;

    function automatic exp_t exp_sum(input idx_t blk, input idx_t lane);
        return {1'b0, blk} + {1'b0, lane};
    endfunction
endpackage

// File: rtl/fft_cbfp_denorm_lane.sv
// One-sample denormalizer: shift by OFFSET - exp, round half up on right shifts,
// saturate to the output width.
module fft_cbfp_denorm_lane
    import fft_pkg::*;
#(
    parameter int WIDTH_IN  = CBFP_WIDTH_IN,
    parameter int WIDTH_OUT = CBFP_WIDTH_OUT,
    parameter int OFFSET    = CBFP_OFFSET
) (
    input  logic signed [WIDTH_IN-1:0]  din,
    input  logic [5:0]                  exp_val,
    output logic signed [WIDTH_OUT-1:0] dout,
    output logic                        sat
);
    localparam int WL = WIDTH_IN + OFFSET;
    // One guard bit beyond WIDTH_IN+1 so the rounding constant at the clamp limit cannot wrap.
    localparam int WR = WIDTH_IN + 2;
    localparam logic [6:0] K_MAX = 7'(WIDTH_IN + 1);
    localparam logic signed [WL-1:0] Y_MAX = WL'((2 ** (WIDTH_OUT - 1)) - 1);
    localparam logic signed [WL-1:0] Y_MIN = WL'(-(2 ** (WIDTH_OUT - 1)));
    localparam logic signed [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    logic signed [6:0]    n;
    logic [6:0]           n_mag;
    logic [6:0]           k;
    logic signed [WR-1:0] half;
    logic signed [WR-1:0] sum;
    logic signed [WR-1:0] rnd;
    logic signed [WL-1:0] y;

    assign n     = $signed(7'(OFFSET)) - $signed({1'b0, exp_val});
    assign n_mag = 7'(-n);
    assign k     = (n_mag > K_MAX) ? K_MAX : n_mag;
    assign half  = WR'(1) << (k - 7'd1);
    assign sum   = WR'(din) + half;
    assign rnd   = sum >>> k;
    assign y     = n[6] ? WL'(rnd) : (WL'(din) <<< n[5:0]);

    always_comb begin
        dout = WIDTH_OUT'(y);
        sat  = 1'b0;
        if (y > Y_MAX) begin
            dout = OUT_MAX;
            sat  = 1'b1;
        end else if (y < Y_MIN) begin
            dout = OUT_MIN;
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/fft_cbfp_denorm.sv
// CBFP denormalizer at the FFT back end: restores true sample magnitude from the
// block and per-lane exponents over a two-stage pipeline.
module fft_cbfp_denorm
    import fft_pkg::*;
#(
    parameter int WIDTH_IN  = CBFP_WIDTH_IN,
    parameter int WIDTH_OUT = CBFP_WIDTH_OUT,
    parameter int OFFSET    = CBFP_OFFSET
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [WIDTH_IN-1:0]  din_i    [0:LANES-1],
    input  logic signed [WIDTH_IN-1:0]  din_q    [0:LANES-1],
    input  logic [4:0]                  blk_idx,
    input  logic [4:0]                  lane_idx [0:LANES-1],
    output logic                        dout_valid,
    output logic signed [WIDTH_OUT-1:0] dout_i   [0:LANES-1],
    output logic signed [WIDTH_OUT-1:0] dout_q   [0:LANES-1],
    output logic                        dout_sop,
    output logic                        dout_eop,
    output logic                        frame_abort,
    output logic                        sat_flag
);
    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    logic [4:0] beat;
    idx_t       blk_hold;
    idx_t       blk_sel;
    logic       in_abort;
    exp_t       exp_in [0:LANES-1];

    logic                       s1_valid;
    logic                       s1_sop;
    logic                       s1_eop;
    logic signed [WIDTH_IN-1:0] s1_i   [0:LANES-1];
    logic signed [WIDTH_IN-1:0] s1_q   [0:LANES-1];
    exp_t                       s1_exp [0:LANES-1];

    logic signed [WIDTH_OUT-1:0] y_i [0:LANES-1];
    logic signed [WIDTH_OUT-1:0] y_q [0:LANES-1];
    logic [LANES-1:0]            sat_i;
    logic [LANES-1:0]            sat_q;

    // The block exponent is live on a block's first beat and held for the remaining three.
    assign blk_sel  = (beat[1:0] == 2'd0) ? blk_idx : blk_hold;
    assign in_abort = !in_valid && (beat != 5'd0);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign exp_in[k] = exp_sum(blk_sel, lane_idx[k]);

        fft_cbfp_denorm_lane #(
            .WIDTH_IN (WIDTH_IN),
            .WIDTH_OUT(WIDTH_OUT),
            .OFFSET   (OFFSET)
        ) u_i (
            .din    (s1_i[k]),
            .exp_val(s1_exp[k]),
            .dout   (y_i[k]),
            .sat    (sat_i[k])
        );

        fft_cbfp_denorm_lane #(
            .WIDTH_IN (WIDTH_IN),
            .WIDTH_OUT(WIDTH_OUT),
            .OFFSET   (OFFSET)
        ) u_q (
            .din    (s1_q[k]),
            .exp_val(s1_exp[k]),
            .dout   (y_q[k]),
            .sat    (sat_q[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat        <= '0;
            blk_hold    <= '0;
            s1_valid    <= 1'b0;
            s1_sop      <= 1'b0;
            s1_eop      <= 1'b0;
            frame_abort <= 1'b0;
            dout_valid  <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            sat_flag    <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_i[k]   <= '0;
                s1_q[k]   <= '0;
                s1_exp[k] <= '0;
                dout_i[k] <= '0;
                dout_q[k] <= '0;
            end
        end else begin
            s1_valid    <= in_valid;
            frame_abort <= in_abort;
            dout_valid  <= s1_valid;

            if (in_valid) begin
                beat   <= beat + 5'd1;
                s1_sop <= (beat == 5'd0);
                s1_eop <= (beat == LAST_BEAT);
                if (beat[1:0] == 2'd0) begin
                    blk_hold <= blk_idx;
                end
                for (int k = 0; k < LANES; k++) begin
                    s1_i[k]   <= din_i[k];
                    s1_q[k]   <= din_q[k];
                    s1_exp[k] <= exp_in[k];
                end
            end else if (in_abort) begin
                beat     <= '0;
                blk_hold <= '0;
            end

            // Beats already in flight drain with their original tags, even across an abort.
            if (s1_valid) begin
                dout_sop <= s1_sop;
                dout_eop <= s1_eop;
                sat_flag <= |{sat_i, sat_q};
                for (int k = 0; k < LANES; k++) begin
                    dout_i[k] <= y_i[k];
                    dout_q[k] <= y_q[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_cbfp_denorm.sv
// Directed self-checking bench for fft_cbfp_denorm: one task per scenario, hand-computed expectations.
module tb_fft_cbfp_denorm;
    import fft_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [12:0] din_i    [0:LANES-1];
    logic signed [12:0] din_q    [0:LANES-1];
    logic [4:0]         blk_idx;
    logic [4:0]         lane_idx [0:LANES-1];
    logic               dout_valid, dout_sop, dout_eop, frame_abort, sat_flag;
    logic signed [15:0] dout_i   [0:LANES-1];
    logic signed [15:0] dout_q   [0:LANES-1];

    logic signed [15:0] ei [0:LANES-1];
    logic signed [15:0] eq [0:LANES-1];
    int n_checks = 0;
    int n_pass   = 0;

    fft_cbfp_denorm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .din_i      (din_i),
        .din_q      (din_q),
        .blk_idx    (blk_idx),
        .lane_idx   (lane_idx),
        .dout_valid (dout_valid),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .frame_abort(frame_abort),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lane(input int l, input int di, input int dq, input int li);
        din_i[l]    = 13'(di);
        din_q[l]    = 13'(dq);
        lane_idx[l] = 5'(li);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; in_valid = 1'b0; blk_idx = 5'd0;
        for (int l = 0; l < LANES; l++) begin
            drive_lane(l, 0, 0, 0);
            ei[l] = 16'sd0; eq[l] = 16'sd0;
        end
        tick(); tick();
        n_checks++;
        if ({dout_valid, dout_sop, dout_eop, frame_abort, sat_flag} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {dout_valid, dout_sop, dout_eop, frame_abort, sat_flag});
        else n_pass++;
        bad = -1;
        for (int l = 0; l < LANES; l++)
            if (bad < 0 && (dout_i[l] !== ei[l] || dout_q[l] !== eq[l])) bad = l;
        n_checks++;
        if (bad >= 0) $display("FAIL reset_data lane %0d got %0d/%0d want 0/0", bad, dout_i[bad], dout_q[bad]);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({dout_valid, frame_abort} !== 2'b00)
            $display("FAIL reset_idle got %b want 00", {dout_valid, frame_abort});
        else n_pass++;
    endtask

    task automatic test_identity();
        int p, bad;
        logic ev;
        blk_idx = 5'd6;
        for (int l = 0; l < LANES; l++) begin
            drive_lane(l, 100, -100, 6);
            ei[l] = 16'sd100; eq[l] = -16'sd100;
        end
        for (int c = 0; c < 35; c++) begin
            in_valid = (c < 32);
            tick();
            p  = c - 1;
            ev = (p >= 0 && p < 32);
            n_checks++;
            if (dout_valid !== ev) $display("FAIL ident_valid c=%0d got %b want %b", c, dout_valid, ev);
            else n_pass++;
            n_checks++;
            if (frame_abort !== 1'b0) $display("FAIL ident_abort c=%0d got %b want 0", c, frame_abort);
            else n_pass++;
            if (ev) begin
                n_checks++;
                if ({dout_sop, dout_eop, sat_flag} !== {p == 0, p == 31, 1'b0})
                    $display("FAIL ident_tags p=%0d got %b want %b", p, {dout_sop, dout_eop, sat_flag}, {p == 0, p == 31, 1'b0});
                else n_pass++;
                bad = -1;
                for (int l = 0; l < LANES; l++)
                    if (bad < 0 && (dout_i[l] !== ei[l] || dout_q[l] !== eq[l])) bad = l;
                n_checks++;
                if (bad >= 0) $display("FAIL ident_data p=%0d lane %0d got %0d/%0d want %0d/%0d",
                                       p, bad, dout_i[bad], dout_q[bad], ei[bad], eq[bad]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rounding();
        int p, bad;
        blk_idx = 5'd9;
        for (int l = 0; l < LANES; l++) begin
            drive_lane(l, l, -l, 3);
            ei[l] = 16'(l); eq[l] = 16'(-l);
        end
        drive_lane(0, 100, -100, 5);   ei[0] = 16'sd25; eq[0] = -16'sd25;
        drive_lane(1, -3, 1, 4);       ei[1] = -16'sd1; eq[1] = 16'sd1;
        drive_lane(2, 3, -1, 4);       ei[2] = 16'sd2;  eq[2] = 16'sd0;
        drive_lane(3, 5, -5, 31);      ei[3] = 16'sd0;  eq[3] = 16'sd0;
        drive_lane(4, 1000, -1000, 11); ei[4] = 16'sd4; eq[4] = -16'sd4;
        drive_lane(5, 4095, -4096, 17); ei[5] = 16'sd0; eq[5] = 16'sd0;
        for (int c = 0; c < 34; c++) begin
            in_valid = (c < 32);
            tick();
            p = c - 1;
            if (p >= 0 && p < 32) begin
                n_checks++;
                if ({dout_valid, sat_flag} !== 2'b10)
                    $display("FAIL round_valid_sat p=%0d got %b want 10", p, {dout_valid, sat_flag});
                else n_pass++;
                bad = -1;
                for (int l = 0; l < LANES; l++)
                    if (bad < 0 && (dout_i[l] !== ei[l] || dout_q[l] !== eq[l])) bad = l;
                n_checks++;
                if (bad >= 0) $display("FAIL round_data p=%0d lane %0d got %0d/%0d want %0d/%0d",
                                       p, bad, dout_i[bad], dout_q[bad], ei[bad], eq[bad]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        int p, bad;
        logic esat;
        blk_idx = 5'd0;
        for (int c = 0; c < 34; c++) begin
            in_valid = (c < 32);
            for (int l = 0; l < LANES; l++) begin
                if (c % 2 == 0) drive_lane(l, 10 * l, -10 * l, 12);
                else            drive_lane(l, 0, 0, 12);
            end
            if (c % 2 == 0) begin
                drive_lane(0, 4095, 0, 0);
                drive_lane(1, -4096, -1, 0);
                drive_lane(2, 7, -7, 3);
            end else begin
                drive_lane(0, 7, -7, 3);
                drive_lane(1, 4095, -4095, 12);
                drive_lane(2, -4096, 4095, 12);
            end
            tick();
            p = c - 1;
            if (p >= 0 && p < 32) begin
                esat = (p % 2 == 0);
                for (int l = 0; l < LANES; l++) begin
                    ei[l] = esat ? 16'(10 * l) : 16'sd0;
                    eq[l] = esat ? 16'(-10 * l) : 16'sd0;
                end
                if (esat) begin
                    ei[0] = 16'sd32767;  eq[0] = 16'sd0;
                    ei[1] = -16'sd32768; eq[1] = -16'sd4096;
                    ei[2] = 16'sd3584;   eq[2] = -16'sd3584;
                end else begin
                    ei[0] = 16'sd3584;   eq[0] = -16'sd3584;
                    ei[1] = 16'sd4095;   eq[1] = -16'sd4095;
                    ei[2] = -16'sd4096;  eq[2] = 16'sd4095;
                end
                n_checks++;
                if ({dout_valid, sat_flag} !== {1'b1, esat})
                    $display("FAIL sat_flag p=%0d got %b want %b", p, {dout_valid, sat_flag}, {1'b1, esat});
                else n_pass++;
                bad = -1;
                for (int l = 0; l < LANES; l++)
                    if (bad < 0 && (dout_i[l] !== ei[l] || dout_q[l] !== eq[l])) bad = l;
                n_checks++;
                if (bad >= 0) $display("FAIL sat_data p=%0d lane %0d got %0d/%0d want %0d/%0d",
                                       p, bad, dout_i[bad], dout_q[bad], ei[bad], eq[bad]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_block_hold();
        int p, bad;
        logic signed [15:0] ev_i;
        for (int l = 0; l < LANES; l++) drive_lane(l, 64, -64, 10);
        for (int c = 0; c < 34; c++) begin
            in_valid = (c < 32);
            if (c % 4 == 0) blk_idx = (c == 4) ? 5'd4 : 5'd2;
            else            blk_idx = 5'd9;
            tick();
            p = c - 1;
            if (p >= 0 && p < 32) begin
                ev_i = (p >= 4 && p <= 7) ? 16'sd16 : 16'sd64;
                n_checks++;
                if (dout_valid !== 1'b1) $display("FAIL hold_valid p=%0d got %b want 1", p, dout_valid);
                else n_pass++;
                bad = -1;
                for (int l = 0; l < LANES; l++)
                    if (bad < 0 && (dout_i[l] !== ev_i || dout_q[l] !== -ev_i)) bad = l;
                n_checks++;
                if (bad >= 0) $display("FAIL hold_data p=%0d lane %0d got %0d/%0d want %0d/%0d",
                                       p, bad, dout_i[bad], dout_q[bad], ev_i, -ev_i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        int p, b, bad, n_out, n_abort;
        logic ev;
        n_out = 0; n_abort = 0;
        blk_idx = 5'd6;
        for (int c = 0; c < 47; c++) begin
            in_valid = (c <= 10) || (c >= 12 && c <= 43);
            b = (c <= 11) ? c : c - 12;
            for (int l = 0; l < LANES; l++) drive_lane(l, b * 5 + l, -b * 5 - l, 6);
            tick();
            if (frame_abort === 1'b1) n_abort++;
            n_checks++;
            if (frame_abort !== (c == 11)) $display("FAIL abort_pulse c=%0d got %b want %b", c, frame_abort, (c == 11));
            else n_pass++;
            p  = c - 1;
            ev = (p >= 0 && p <= 10) || (p >= 12 && p <= 43);
            n_checks++;
            if (dout_valid !== ev) $display("FAIL abort_valid c=%0d got %b want %b", c, dout_valid, ev);
            else n_pass++;
            if (ev && dout_valid === 1'b1) begin
                if (p <= 10) n_out++;
                b = (p <= 10) ? p : p - 12;
                n_checks++;
                if ({dout_sop, dout_eop, sat_flag} !== {b == 0, b == 31, 1'b0})
                    $display("FAIL abort_tags p=%0d got %b want %b", p, {dout_sop, dout_eop, sat_flag}, {b == 0, b == 31, 1'b0});
                else n_pass++;
                for (int l = 0; l < LANES; l++) begin
                    ei[l] = 16'(b * 5 + l); eq[l] = 16'(-b * 5 - l);
                end
                bad = -1;
                for (int l = 0; l < LANES; l++)
                    if (bad < 0 && (dout_i[l] !== ei[l] || dout_q[l] !== eq[l])) bad = l;
                n_checks++;
                if (bad >= 0) $display("FAIL abort_data p=%0d lane %0d got %0d/%0d want %0d/%0d",
                                       p, bad, dout_i[bad], dout_q[bad], ei[bad], eq[bad]);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_abort != 1) $display("FAIL abort_count got %0d want 1", n_abort);
        else n_pass++;
        n_checks++;
        if (n_out != 11) $display("FAIL abort_beats got %0d want 11", n_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back_reset();
        int p, b, fb, bad, n_contig;
        logic ev;
        n_contig = 0;
        blk_idx = 5'd6;
        for (int c = 0; c < 120; c++) begin
            rst_n    = (c != 84);
            in_valid = (c <= 84) || (c >= 86 && c <= 117);
            b = (c < 84) ? c % 32 : ((c == 84) ? 20 : c - 86);
            for (int l = 0; l < LANES; l++) drive_lane(l, b * 7 - 3 * l, 5 * l - b, 6);
            tick();
            p = c - 1;
            if (c == 84) begin
                n_checks++;
                if ({dout_valid, dout_sop, dout_eop, frame_abort, sat_flag} !== 5'b0)
                    $display("FAIL b2b_reset_ctrl got %b want 00000", {dout_valid, dout_sop, dout_eop, frame_abort, sat_flag});
                else n_pass++;
                bad = -1;
                for (int l = 0; l < LANES; l++)
                    if (bad < 0 && (dout_i[l] !== 16'sd0 || dout_q[l] !== 16'sd0)) bad = l;
                n_checks++;
                if (bad >= 0) $display("FAIL b2b_reset_data lane %0d got %0d/%0d want 0/0", bad, dout_i[bad], dout_q[bad]);
                else n_pass++;
            end else begin
                n_checks++;
                if (frame_abort !== 1'b0) $display("FAIL b2b_abort c=%0d got %b want 0", c, frame_abort);
                else n_pass++;
                ev = (p >= 0 && p < 84) || (p >= 86 && p <= 117);
                n_checks++;
                if (dout_valid !== ev) $display("FAIL b2b_valid c=%0d got %b want %b", c, dout_valid, ev);
                else n_pass++;
                if (ev && dout_valid === 1'b1) begin
                    if (p < 64) n_contig++;
                    fb = (p < 84) ? p % 32 : p - 86;
                    n_checks++;
                    if ({dout_sop, dout_eop} !== {fb == 0, fb == 31})
                        $display("FAIL b2b_tags p=%0d got %b want %b", p, {dout_sop, dout_eop}, {fb == 0, fb == 31});
                    else n_pass++;
                    for (int l = 0; l < LANES; l++) begin
                        ei[l] = 16'(fb * 7 - 3 * l); eq[l] = 16'(5 * l - fb);
                    end
                    bad = -1;
                    for (int l = 0; l < LANES; l++)
                        if (bad < 0 && (dout_i[l] !== ei[l] || dout_q[l] !== eq[l])) bad = l;
                    n_checks++;
                    if (bad >= 0) $display("FAIL b2b_data p=%0d lane %0d got %0d/%0d want %0d/%0d",
                                           p, bad, dout_i[bad], dout_q[bad], ei[bad], eq[bad]);
                    else n_pass++;
                end
            end
        end
        rst_n = 1'b1;
        n_checks++;
        if (n_contig != 64) $display("FAIL b2b_contiguous got %0d want 64", n_contig);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rounding();
        test_saturation();
        test_block_hold();
        test_abort();
        test_back_to_back_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
